store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//  Posted-store FIFO between the EX/MEM pipeline register and the data memory port. Accepts sw/sh/sb
//  from MEM stage, drains one per cycle into data memory. Memory port is shared: load in MEM has
//  priority; a load whose word address matches any pending store stalls until those stores drain.
// PARAMETERS
//  DEPTH  4  entries; power of 2, >=2
//  PTRW   2  log2(DEPTH); pointer width
// PORTS
//  clk        in   1   clock, all state on posedge
//  reset      in   1   asynchronous, active-high; clears all state
//  st_valid   in   1   MEM stage presents a store this cycle
//  st_ready   out  1   buffer accepts store this cycle (= !full)
//  st_addr    in   32  byte address of store
//  st_data    in   32  store data, right-aligned (half in [15:0], byte in [7:0])
//  st_size    in   2   0 word, 1 half, 2 byte; 3 illegal (entry dropped, not written)
//  st_pc      in   32  PC of store instruction, carried for memory write trace
//  ld_req     in   1   MEM stage load needs memory port this cycle
//  ld_addr    in   32  load byte address
//  ld_mode    in   4   load mode to memory (size in [2:1], sign in [0])
//  ld_stall   out  1   load must hold: word conflict with a pending entry
//  mem_addr   out  32  memory address
//  mem_mode   out  4   memory load/write mode
//  mem_we     out  1   memory write enable
//  mem_wdata  out  32  memory write data
//  mem_pc     out  32  PC tagged to memory write
//  empty      out  1   no pending stores
// BEHAVIOUR
//  Storage: DEPTH entries {addr, data, size, pc}; head/tail pointers PTRW bits, wrap modulo DEPTH;
//   count PTRW+1 bits. full = count==DEPTH, empty = count==0.
//  Reset (async): head=tail=count=0; entry contents don't care. Outputs after reset: st_ready=1,
//   empty=1, mem_we=0, ld_stall=0, mem_addr/mem_mode/mem_wdata/mem_pc follow port mux (see below).
//   Reset mid-drain: pending stores discarded, never written; no partial write.
//  Push: st_valid && st_ready at posedge -> entry written at tail, tail++, count++. st_ready derives
//   from current count only; no pass-through when full even if pop occurs same cycle.
//  Conflict: conflict = ld_req && any valid entry with addr[31:2]==ld_addr[31:2]. ld_stall = conflict
//   (combinational). Incoming store in same cycle is not compared (not yet in buffer; MEM stage order
//   guarantees load and store are not both presented in one cycle).
//  Port mux (combinational):
//   ld_req && !ld_stall -> load owns port: mem_addr=ld_addr, mem_mode=ld_mode, mem_we=0.
//   else !empty -> drain head: mem_addr=head.addr, mem_mode={1'b0,head.size,1'b0}, mem_wdata=head.data,
//     mem_pc=head.pc, mem_we=1 (0 if head.size==3).
//   else idle: mem_addr=ld_addr, mem_mode=ld_mode, mem_we=0, mem_wdata=0, mem_pc=0.
//  Pop: drain selected at posedge -> head++, count-- (also for size==3, silently discarded).
//  Simultaneous push+pop: count unchanged, both pointers advance.
//  Latency: store pushed at edge N is earliest written at edge N+1; empty-buffer store with no load
//   traffic is in memory after exactly 2 edges from presentation. Order of writes = order of pushes.
//  Progress: ld_stall forces drain each cycle, so a stalled load waits at most count cycles.
// STRUCTURE
//  Shared package/header: MEM_SIZE_WORD=2'd0, MEM_SIZE_HALF=2'd1, MEM_SIZE_BYTE=2'd2; mode field
//   layout (size [2:1], sign [0]) shared with data memory and control decoder.
//  One natural sub-module: sb_match (DEPTH-wide word-address comparator masked by valid bits,
//   valid derived from head/count). Pointer/count logic and port mux stay in top.
// TESTING
//  1 Reset, then sw 0x0000_0010<=0x1234_5678 with no loads -> mem_we=1 next cycle, addr 0x10,
//    mode 4'b0000, wdata 0x12345678, pc tagged; empty=1 after.
//  2 Four back-to-back stores while ld_req held with non-conflicting addr -> st_ready=0 on 5th;
//    no mem_we while loads run; release ld_req -> 4 writes in push order, 1/cycle.
//  3 sb 0x13<=0xAB pending, lb 0x10 requested -> ld_stall=1 one cycle, write drains (mode 4'b0100),
//    next cycle ld_stall=0, mem_addr=0x10, mem_mode=ld_mode.
//  4 Full buffer, push and pop same cycle -> push refused (st_ready was 0), count 3; next cycle push
//    accepted; tail wraps 3->0 correctly, data intact.
//  5 Two stores pending, assert reset mid-cycle (async) -> mem_we drops immediately, empty=1, no
//    further writes after deassert.
//  6 Store with st_size=3 -> popped with mem_we=0, memory unchanged, following sh 0x22 written
//    with mode 4'b0010.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared memory-port encodings and the store buffer entry layout.
// The mode field layout (size [2:1], sign [0]) is also used by the data memory and control decoder.
package store_buffer_pkg;

  localparam logic [1:0] MEM_SIZE_WORD = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'd2;
  localparam logic [1:0] MEM_SIZE_BAD  = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] pc;
  } sb_entry_t;

  // Stores are always unsigned in the mode field.
  function automatic logic [3:0] store_mode(input logic [1:0] size);
    return {1'b0, size, 1'b0};
  endfunction

endpackage

// File: rtl/sb_match.sv
// Word-address comparator across all buffer slots, masked to the slots that hold pending stores.
// A slot is pending when its distance from head (mod DEPTH) is below count.
module sb_match #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic [PTRW-1:0]         head_i,
  input  logic [PTRW:0]           count_i,
  input  logic [DEPTH-1:0][29:0]  waddr_i,
  input  logic [29:0]             ld_waddr_i,
  input  logic                    ld_req_i,
  output logic                    hit_o
);

  logic [PTRW-1:0] off;
  logic            hit;

  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTRW'(i) - head_i;
      if (({1'b0, off} < count_i) && (waddr_i[i] == ld_waddr_i)) begin
        hit = 1'b1;
      end
    end
  end

  assign hit_o = ld_req_i && hit;

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO between MEM stage and the data memory port; drains one store per cycle
// whenever a load does not own the port. Loads hitting a pending store word stall until it drains.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_pc,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_mode,
  output logic        ld_stall,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_mode,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_pc,
  output logic        empty
);

  sb_entry_t              ent_q [DEPTH];
  logic [PTRW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [PTRW:0]          count_q, count_d;
  logic [DEPTH-1:0][29:0] waddr;
  sb_entry_t              head_ent;
  logic                   full, push, pop, load_own;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      waddr[i] = ent_q[i].addr[31:2];
    end
  end

  sb_match #(.DEPTH(DEPTH), .PTRW(PTRW)) u_match (
    .head_i    (head_q),
    .count_i   (count_q),
    .waddr_i   (waddr),
    .ld_waddr_i(ld_addr[31:2]),
    .ld_req_i  (ld_req),
    .hit_o     (ld_stall)
  );

  assign full     = (count_q == (PTRW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign push     = st_valid && !full;
  assign load_own = ld_req && !ld_stall;
  // A stalled load cannot own the port, so a conflict always forces a drain.
  assign pop      = !load_own && !empty;
  assign head_ent = ent_q[head_q];

  always_comb begin
    mem_addr  = ld_addr;
    mem_mode  = ld_mode;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_pc    = '0;
    if (!load_own && !empty) begin
      mem_addr  = head_ent.addr;
      mem_mode  = store_mode(head_ent.size);
      mem_wdata = head_ent.data;
      mem_pc    = head_ent.pc;
      mem_we    = (head_ent.size != MEM_SIZE_BAD);
    end
  end

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: only slots covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_q[tail_q] <= '{addr: st_addr, data: st_data, size: st_size, pc: st_pc};
    end
  end

endmodule
